// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage plus IF/ID pipeline register of the 5-stage CPU.
// Owns the PC, fetches from a variable-latency instruction memory over a
// req/ack handshake, honours the hazard unit's PCwrite/Stall and the branch
// unit's Flush/target, and presents PC/instruction/valid to ID.
//
// Parameters:
//   PC_RESET      PC value loaded on reset
//   IMEM_TIMEOUT  max wait cycles for imem_ack_i before fetch_err_o (2..255)
//
// Ports:
//   clk_i, rst_i            clock (rising edge), async active-low reset
//   start_i                 begin fetching (sampled only in IDLE)
//   PCwrite_i, Stall_i      hazard unit: 0 = hold PC / 1 = hold IF/ID
//   Flush_i, BranchTarget_i branch taken in ID: squash IF/ID, redirect PC
//   imem_req_o, imem_addr_o instruction memory request and word address
//   imem_ack_i, imem_data_i fetch complete, fetched instruction
//   IFID_PC_o, IFID_Instr_o, IFID_Valid_o   IF/ID register contents
//   fetch_err_o             sticky ack-timeout error
//
// Optional build macro FETCH_STATS_EN adds fetch_count_o / flush_count_o.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module if_fetch_stage #(
  parameter logic [31:0] PC_RESET     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PCwrite_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] BranchTarget_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] IFID_PC_o,
  output logic [31:0] IFID_Instr_o,
  output logic        IFID_Valid_o,
  output logic        fetch_err_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] flush_count_o
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(IMEM_TIMEOUT - 1);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  state_t      state, state_d;
  logic [31:0] pc_p0, pc_d;
  logic [31:0] drain_addr_p0, drain_addr_d;
  logic [7:0]  wait_cnt, wait_d;
  logic        err_q, err_d;

  logic [31:0] buf_pc_p0, buf_pc_d;
  logic [31:0] buf_instr_p0, buf_instr_d;
  logic        buf_vld_p0, buf_vld_d;

  logic [31:0] ifid_pc_p1, ifid_pc_d;
  logic [31:0] ifid_instr_p1, ifid_instr_d;
  logic        vld_p1, vld_d;

  logic        hold;
  logic        ack;
  logic        timeout_hit;
  logic        load_vld;
  logic        flush_acc;

  assign hold        = Stall_i | ~PCwrite_i;
  assign imem_req_o  = (state == REQ) || (state == DRAIN);
  // Acks outside an active request are meaningless and dropped here.
  assign ack         = imem_ack_i & imem_req_o;
  assign timeout_hit = (wait_cnt == TO_LAST);
  // DRAIN keeps presenting the address of the request still in flight,
  // even though pc_p0 already points at the branch target.
  assign imem_addr_o = (state == DRAIN) ? drain_addr_p0 : word_align(pc_p0);

  assign IFID_PC_o    = ifid_pc_p1;
  assign IFID_Instr_o = ifid_instr_p1;
  assign IFID_Valid_o = vld_p1;
  assign fetch_err_o  = err_q;

  always_comb begin
    state_d      = state;
    pc_d         = pc_p0;
    drain_addr_d = drain_addr_p0;
    wait_d       = wait_cnt;
    err_d        = err_q;
    buf_pc_d     = buf_pc_p0;
    buf_instr_d  = buf_instr_p0;
    buf_vld_d    = buf_vld_p0;
    ifid_pc_d    = ifid_pc_p1;
    ifid_instr_d = ifid_instr_p1;
    vld_d        = vld_p1;
    load_vld     = 1'b0;
    flush_acc    = 1'b0;

    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_d = REQ;
          wait_d  = 8'd0;
        end
      end

      REQ: begin
        if (Flush_i) begin
          // Flush beats both hold and a same-cycle ack.
          flush_acc    = 1'b1;
          vld_d        = 1'b0;
          ifid_instr_d = 32'h0;
          pc_d         = word_align(BranchTarget_i);
          buf_vld_d    = 1'b0;
          wait_d       = 8'd0;
          if (!ack) begin
            drain_addr_d = word_align(pc_p0);
            state_d      = DRAIN;
          end
        end else if (ack) begin
          wait_d = 8'd0;
          if (!hold) begin
            ifid_pc_d    = pc_p0;
            ifid_instr_d = imem_data_i;
            vld_d        = 1'b1;
            load_vld     = 1'b1;
            pc_d         = pc_inc(pc_p0);
          end else begin
            buf_pc_d    = pc_p0;
            buf_instr_d = imem_data_i;
            buf_vld_d   = 1'b1;
            state_d     = HOLD;
          end
        end else if (timeout_hit) begin
          err_d        = 1'b1;
          vld_d        = 1'b0;
          ifid_instr_d = 32'h0;
          state_d      = ERR;
        end else begin
          wait_d = sat_inc(wait_cnt);
          if (!hold) begin
            vld_d        = 1'b0;
            ifid_instr_d = 32'h0;
          end
        end
      end

      HOLD: begin
        if (Flush_i) begin
          flush_acc    = 1'b1;
          vld_d        = 1'b0;
          ifid_instr_d = 32'h0;
          pc_d         = word_align(BranchTarget_i);
          buf_vld_d    = 1'b0;
          wait_d       = 8'd0;
          state_d      = REQ;
        end else if (!hold) begin
          ifid_pc_d    = buf_pc_p0;
          ifid_instr_d = buf_instr_p0;
          vld_d        = buf_vld_p0;
          load_vld     = buf_vld_p0;
          pc_d         = pc_inc(pc_p0);
          buf_vld_d    = 1'b0;
          state_d      = REQ;
        end
      end

      DRAIN: begin
        if (Flush_i) begin
          // A second redirect while still draining: retarget, keep draining.
          flush_acc    = 1'b1;
          vld_d        = 1'b0;
          ifid_instr_d = 32'h0;
          pc_d         = word_align(BranchTarget_i);
          buf_vld_d    = 1'b0;
          wait_d       = 8'd0;
          if (ack) begin
            state_d = REQ;
          end
        end else if (ack) begin
          // Stale word from the squashed path is dropped.
          wait_d  = 8'd0;
          state_d = REQ;
        end else if (timeout_hit) begin
          err_d        = 1'b1;
          vld_d        = 1'b0;
          ifid_instr_d = 32'h0;
          state_d      = ERR;
        end else begin
          wait_d = sat_inc(wait_cnt);
        end
      end

      ERR: begin
        // Frozen until reset.
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- IF stage / IF-ID register boundary ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      pc_p0         <= PC_RESET;
      drain_addr_p0 <= 32'h0;
      wait_cnt      <= 8'd0;
      err_q         <= 1'b0;
      buf_vld_p0    <= 1'b0;
      ifid_pc_p1    <= 32'h0;
      ifid_instr_p1 <= 32'h0;
      vld_p1        <= 1'b0;
    end else begin
      state         <= state_d;
      pc_p0         <= pc_d;
      drain_addr_p0 <= drain_addr_d;
      wait_cnt      <= wait_d;
      err_q         <= err_d;
      buf_vld_p0    <= buf_vld_d;
      ifid_pc_p1    <= ifid_pc_d;
      ifid_instr_p1 <= ifid_instr_d;
      vld_p1        <= vld_d;
    end
  end

  // Hold-buffer payload is qualified by buf_vld_p0 and needs no reset.
  always_ff @(posedge clk_i) begin
    buf_pc_p0    <= buf_pc_d;
    buf_instr_p0 <= buf_instr_d;
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (load_vld) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (flush_acc) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count_o = fetch_cnt_q;
  assign flush_count_o = flush_cnt_q;
`else
  // Strobes exist for the statistics build only.
  logic stats_unused;
  assign stats_unused = load_vld ^ flush_acc;
`endif

endmodule
